// File: rtl/deque_if.sv
// rtl/deque_if.sv - select/request/data bundle between a bus master and the deque
interface deque_if #(
  parameter int WORDS = 16
);
  localparam int AW = $clog2(WORDS);

  logic          deque_select;
  logic          push_front;
  logic          pop_front;
  logic          push_back;
  logic          pop_back;
  logic [7:0]    data_front_in;
  logic [7:0]    data_back_in;
  logic [7:0]    data_front_out;
  logic [7:0]    data_back_out;
  logic [AW:0]   count;
  logic          empty;
  logic          full;

  modport master (
    output deque_select, push_front, pop_front, push_back, pop_back,
    output data_front_in, data_back_in,
    input  data_front_out, data_back_out, count, empty, full
  );

  modport slave (
    input  deque_select, push_front, pop_front, push_back, pop_back,
    input  data_front_in, data_back_in,
    output data_front_out, data_back_out, count, empty, full
  );
endinterface

// File: rtl/deque.sv
// rtl/deque.sv - byte-wide double-ended queue on a circular buffer, push/pop at both ends
module deque #(
  parameter int ADDR  = 0,
  parameter int WORDS = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  deque_if.slave bus
);
  localparam int          AW       = $clog2(WORDS);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(WORDS);
  localparam logic [31:0] ADDR_W   = ADDR;

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [WORDS];
  logic [7:0]    mem_d [WORDS];

  logic          sel;
  logic          fpush, fpop, bpush, bpop;
  logic [AW:0]   mid;
  logic [AW-1:0] tail_m1;

  assign sel     = ({31'b0, bus.deque_select} == ADDR_W);
  assign tail_m1 = tail_q - AW'(1);

  // Front end is resolved first; the back end sees the post-front occupancy.
  always_comb begin
    fpush   = sel & bus.push_front & (count_q < FULL_CNT);
    fpop    = sel & bus.pop_front & ~bus.push_front & (count_q != '0);
    mid     = count_q + {{AW{1'b0}}, fpush} - {{AW{1'b0}}, fpop};
    bpush   = sel & bus.push_back & (mid < FULL_CNT);
    bpop    = sel & bus.pop_back & ~bus.push_back & (mid != '0);
    count_d = mid + {{AW{1'b0}}, bpush} - {{AW{1'b0}}, bpop};

    head_d = head_q;
    tail_d = tail_q;
    mem_d  = mem_q;

    if (fpush) begin
      head_d        = head_q - AW'(1);
      mem_d[head_d] = bus.data_front_in;
    end else if (fpop) begin
      head_d = head_q + AW'(1);
    end

    if (bpush) begin
      mem_d[tail_q] = bus.data_back_in;
      tail_d        = tail_q + AW'(1);
    end else if (bpop) begin
      tail_d = tail_m1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign bus.data_front_out = (sel && count_q != '0) ? mem_q[head_q]  : 8'h00;
  assign bus.data_back_out  = (sel && count_q != '0) ? mem_q[tail_m1] : 8'h00;
  assign bus.count          = count_q;
  assign bus.empty          = (count_q == '0);
  assign bus.full           = (count_q == FULL_CNT);
endmodule

// File: tb/tb_deque.sv
// tb/tb_deque.sv - directed vector table plus hand sequences for the deque
module tb_deque;
  localparam int WORDS = 16;

  typedef struct {
    logic       sel, pf, qf, pb, qb;
    logic [7:0] dfi, dbi;
    logic [4:0] cnt;
    logic [7:0] fo, bo;
    logic       e, f;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;
  vec_t vecs [16];

  deque_if #(.WORDS(WORDS)) bus ();

  deque #(.ADDR(0), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic s, logic pf, logic qf, logic pb, logic qb,
                              logic [7:0] dfi, logic [7:0] dbi, logic [4:0] c,
                              logic [7:0] fo, logic [7:0] bo, logic e, logic f);
    vec_t v;
    v.sel = s; v.pf = pf; v.qf = qf; v.pb = pb; v.qb = qb;
    v.dfi = dfi; v.dbi = dbi; v.cnt = c; v.fo = fo; v.bo = bo; v.e = e; v.f = f;
    return v;
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic check_all(string nm, logic [4:0] c, logic [7:0] fo, logic [7:0] bo,
                           logic e, logic f);
    cmp({nm, ".count"}, 32'(bus.count), 32'(c));
    cmp({nm, ".front"}, 32'(bus.data_front_out), 32'(fo));
    cmp({nm, ".back"},  32'(bus.data_back_out),  32'(bo));
    cmp({nm, ".empty"}, 32'(bus.empty), 32'(e));
    cmp({nm, ".full"},  32'(bus.full),  32'(f));
  endtask

  task automatic set_in(logic s, logic pf, logic qf, logic pb, logic qb,
                        logic [7:0] dfi, logic [7:0] dbi);
    bus.deque_select = s;
    bus.push_front = pf; bus.pop_front = qf;
    bus.push_back = pb;  bus.pop_back = qb;
    bus.data_front_in = dfi; bus.data_back_in = dbi;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(0,0,0,0,0, 8'h00,8'h00, 5'd0, 8'h00,8'h00, 1,0);
    vecs[1]  = mk(0,0,0,1,0, 8'h00,8'h11, 5'd1, 8'h11,8'h11, 0,0);
    vecs[2]  = mk(0,0,0,1,0, 8'h00,8'h22, 5'd2, 8'h11,8'h22, 0,0);
    vecs[3]  = mk(0,0,0,1,0, 8'h00,8'h33, 5'd3, 8'h11,8'h33, 0,0);
    vecs[4]  = mk(0,0,1,0,0, 8'h00,8'h00, 5'd2, 8'h22,8'h33, 0,0);
    vecs[5]  = mk(0,0,0,0,1, 8'h00,8'h00, 5'd1, 8'h22,8'h22, 0,0);
    vecs[6]  = mk(0,0,1,0,0, 8'h00,8'h00, 5'd0, 8'h00,8'h00, 1,0);
    vecs[7]  = mk(0,0,1,1,0, 8'h00,8'h44, 5'd1, 8'h44,8'h44, 0,0);
    vecs[8]  = mk(0,0,0,0,1, 8'h00,8'h00, 5'd0, 8'h00,8'h00, 1,0);
    vecs[9]  = mk(0,1,0,0,1, 8'h77,8'h00, 5'd0, 8'h00,8'h00, 1,0);
    vecs[10] = mk(0,1,0,1,0, 8'h66,8'h88, 5'd2, 8'h66,8'h88, 0,0);
    vecs[11] = mk(0,0,1,0,1, 8'h00,8'h00, 5'd0, 8'h00,8'h00, 1,0);
    vecs[12] = mk(0,0,0,1,0, 8'h00,8'h99, 5'd1, 8'h99,8'h99, 0,0);
    vecs[13] = mk(1,1,1,1,1, 8'hEE,8'hDD, 5'd1, 8'h00,8'h00, 0,0);
    vecs[14] = mk(0,0,0,0,0, 8'h00,8'h00, 5'd1, 8'h99,8'h99, 0,0);
    vecs[15] = mk(0,0,1,0,1, 8'h00,8'h00, 5'd0, 8'h00,8'h00, 1,0);

    set_in(0,0,0,0,0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 5'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      set_in(vecs[i].sel, vecs[i].pf, vecs[i].qf, vecs[i].pb, vecs[i].qb,
             vecs[i].dfi, vecs[i].dbi);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].fo, vecs[i].bo,
                vecs[i].e, vecs[i].f);
    end

    for (int i = 0; i < 16; i++) begin
      set_in(0,1,0,0,0, 8'(8'hA0 + i), 8'h00);
      step();
    end
    check_all("fill16", 5'd16, 8'hAF, 8'hA0, 1'b0, 1'b1);
    set_in(0,1,0,0,0, 8'hBB, 8'h00);
    step();
    check_all("push17", 5'd16, 8'hAF, 8'hA0, 1'b0, 1'b1);
    set_in(0,0,1,1,0, 8'h00, 8'h55);
    step();
    check_all("full_popf_pushb", 5'd16, 8'hAE, 8'h55, 1'b0, 1'b1);

    set_in(0,0,0,0,1, 8'h00, 8'h00);
    step();
    check_all("to15", 5'd15, 8'hAE, 8'hA0, 1'b0, 1'b0);
    set_in(0,1,0,1,0, 8'h01, 8'h02);
    step();
    check_all("cnt15_both_push", 5'd16, 8'h01, 8'hA0, 1'b0, 1'b1);
    set_in(0,1,0,1,0, 8'h03, 8'h04);
    step();
    check_all("full_both_push", 5'd16, 8'h01, 8'hA0, 1'b0, 1'b1);

    set_in(0,0,1,0,0, 8'h00, 8'h00);
    repeat (16) step();
    check_all("drained", 5'd0, 8'h00, 8'h00, 1'b1, 1'b0);

    // FIFO use through the back/front ends walks both pointers around the ring.
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) begin
        set_in(0,0,0,1,0, 8'h00, 8'(8'hC0 + k));
        step();
        cmp($sformatf("wrap%0d.count", k), 32'(bus.count), 32'd1);
        cmp($sformatf("wrap%0d.front", k), 32'(bus.data_front_out), 32'(8'hC0 + k));
        cmp($sformatf("wrap%0d.back", k),  32'(bus.data_back_out),  32'(8'hC0 + k));
      end else begin
        set_in(0,0,1,0,0, 8'h00, 8'h00);
        step();
        cmp($sformatf("wrap%0d.count", k), 32'(bus.count), 32'd0);
      end
    end

    set_in(0,0,0,1,0, 8'h00, 8'hC1);
    step();
    set_in(0,0,0,1,0, 8'h00, 8'hC2);
    step();
    check_all("pre_reset", 5'd2, 8'hC1, 8'hC2, 1'b0, 1'b0);
    set_in(0,0,0,1,0, 8'h00, 8'hC3);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 5'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    step();
    check_all("held_reset", 5'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    rst_n = 1'b1;
    set_in(0,0,0,0,0, 8'h00, 8'h00);
    step();
    check_all("post_reset", 5'd0, 8'h00, 8'h00, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/deque.md
Name: deque

Overview:
- Double-ended queue: circular buffer with push/pop at both the front end and the back end. It is the two-ended counterpart of the single-ended LIFO in the same design.
- Sits beside the stacks on the shared select/data bus and is addressed by `deque_select`.
- Read data at each end is combinational.
- All state updates happen on the rising clock edge.

Parameters:
- ADDR, 0, select value at which this instance responds.
- WORDS, 16, storage depth in bytes; must be a power of two, at least 2. `AW = $clog2(WORDS)`.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- deque_select  input  1  instance select; the instance acts only when `deque_select == ADDR`.
- push_front  input  1  push `data_front_in` at the front.
- pop_front  input  1  remove the front element.
- push_back  input  1  push `data_back_in` at the back.
- pop_back  input  1  remove the back element.
- data_front_in  input  8  byte for a front push.
- data_back_in  input  8  byte for a back push.
- data_front_out  output  8  current front element.
- data_back_out  output  8  current back element.
- count  output  AW+1  number of stored elements, 0..WORDS.
- empty  output  1  `count == 0`.
- full  output  1  `count == WORDS`.

Behaviour:
- State: `head` (AW bits, index of front element), `tail` (AW bits, index one past back element), `count` (AW+1 bits), storage `MEM[WORDS]`.
- Reset (`rst_n` low, asynchronous, any cycle including mid-operation):
  - `head = tail = 0`, `count = 0`, all `MEM` entries = 0.
  - Outputs: `empty = 1`, `full = 0`, `data_*_out = 0`.
- Outputs:
  - `data_front_out = MEM[head]`; `data_back_out = MEM[tail-1]` (mod WORDS).
  - Both data outputs are 0 when empty or when not selected.
  - `count`, `empty` and `full` are always driven, independent of select.
- Not selected: no state change, regardless of request inputs.
- Per end, push has priority over pop; if both are asserted at one end, the pop is ignored.
- Acceptance, evaluated in order from registered `count` (single-cycle, no stall/handshake; rejected requests are dropped silently):
  - `fpush = push_front & (count < WORDS)`.
  - `fpop = pop_front & ~push_front & (count > 0)`.
  - `mid = count + fpush - fpop`.
  - `bpush = push_back & (mid < WORDS)`.
  - `bpop = pop_back & ~push_back & (mid > 0)`.
- Updates at the clock edge, all pointer arithmetic modulo WORDS:
  - `fpush`: `MEM[head-1] <= data_front_in`; `head <= head-1`.
  - `fpop`: `head <= head+1`.
  - `bpush`: `MEM[tail] <= data_back_in`; `tail <= tail+1`.
  - `bpop`: `tail <= tail-1`.
  - `count <= mid + bpush - bpop`.
- Latency: a pushed byte is visible on the corresponding `data_*_out` the cycle after acceptance. A pop takes effect at the next edge.
- Boundary conditions:
  - Full with both pushes: both rejected.
  - `count == WORDS-1` with both pushes: front accepted, back rejected.
  - `count == 1` with both pops: front accepted, back rejected.
  - Full with `pop_front` + `push_back`: both accepted; the back write reuses the freed slot; `count` stays WORDS.
  - Empty with `push_front` + `pop_back`: both accepted; the front byte passes straight through; `count` stays 0, `head == tail`.
  - Empty with `push_back` + `pop_front`: push accepted, pop rejected; `count = 1`.
  - Pointers wrap silently. Invariant: `tail == head + count` (mod WORDS).
  - With `count == 1`, `data_front_out == data_back_out`.

Test Plan:
- Reset, then select with `push_back` of 0x11, 0x22, 0x33 over 3 cycles -> `count = 3`; `data_front_out = 0x11`; `data_back_out = 0x33`.
- From that state, `pop_front` for 1 cycle, then `pop_back` for 1 cycle -> front = back = 0x22, `count = 1`. Then `pop_front` -> `empty = 1`, both outputs 0.
- `push_front` of 0xA0..0xAF (16 values, WORDS = 16) -> `full = 1`, front = 0xAF, back = 0xA0. A 17th `push_front` is ignored. Then `pop_front` + `push_back` 0x55 in one cycle -> `count = 16`, front = 0xAE, back = 0x55.
- `count = 15` with `push_front` 0x01 + `push_back` 0x02 -> `count = 16`; front = 0x01; back unchanged.
- Empty with `push_front` 0x77 + `pop_back` -> `count = 0`, `empty = 1`. Wrap check: 40 alternating back-push/front-pop cycles -> data in FIFO order throughout, `count` never exceeds 1.
- Select mismatch (`deque_select != ADDR`) with all requests asserted -> no state change, data outputs 0. Assert `rst_n` low asynchronously mid-burst -> `count = 0` and `empty = 1` immediately, without waiting for a clock edge.
